exc_pipe: RTL and testbench
===========================

Name: exc_pipe

Overview:
- Exception-tracking pipeline that sits directly upstream of the coprocessor-0 register block in the 5-stage MIPS core.
- Carries each instruction's PC and first-detected exception code alongside the F→D→E→M pipeline registers.
- Merges new exception sources raised in each stage.
- Presents the M-stage victim PC and exception code to CP0 (its VPC / ExcCodeIn inputs).
- Flushes itself when CP0 raises Req.

Parameters:
- PC_LO, 32'h0000_3000, lowest legal instruction address.
- PC_HI, 32'h0000_6FFC, highest legal instruction address.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard stall: hold D register, insert bubble into E.
- Req  in  1  CP0 exception request: flush D, E, M on next edge.
- F_PC  in  32  PC of instruction in F.
- D_RI  in  1  reserved/unknown instruction decoded in D.
- D_Syscall  in  1  syscall decoded in D.
- E_Ov  in  1  arithmetic overflow in E (add/addi/sub).
- E_AddrOv  in  1  load/store address-calculation overflow in E.
- E_IsLoad  in  1  E instruction is a load.
- M_AdEL  in  1  misaligned or illegal load address in M.
- M_AdES  in  1  misaligned or illegal store address in M.
- M_VPC  out  32  victim PC to CP0.
- M_ExcCode  out  5  exception code to CP0; 0 = none.
- D_PC  out  32  registered D-stage PC.
- E_PC  out  32  registered E-stage PC.

Behaviour:
- Codes (package constants): EXC_NONE=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
- F-stage exception:
  - F_PC[1:0]!=0 or F_PC<PC_LO or F_PC>PC_HI ⇒ F code = ADEL.
  - Otherwise F code = NONE.
- First exception wins: each stage's outgoing code = incoming registered code if nonzero, else that stage's local code.
- D local code priority: RI over SYSCALL.
- E local code:
  - E_Ov ⇒ OV.
  - E_AddrOv ⇒ ADEL if E_IsLoad, else ADES.
  - E_Ov and E_AddrOv are never both set; if both are set, OV wins.
- M local code: AdEL over AdES.
- M_ExcCode and M_VPC are combinational from the M register plus the M local code.
- M_VPC = M-stage registered PC.
- Latency: F-detected code appears on M_ExcCode exactly 3 edges after F_PC is presented, with no stalls.
- Registers (PC, code) for D, E, M update on every posedge in this priority order:
  1. Reset: all PC registers = PC_LO, all codes = 0. Outputs after reset: M_VPC=PC_LO, M_ExcCode=0, D_PC=E_PC=PC_LO.
  2. Req: D, E, M codes = 0. PCs are loaded normally (F_PC→D, D→E, E→M) so bubbles still carry a meaningful PC.
  3. Stall: D holds. E gets a bubble with code 0 and PC = D_PC. M advances from E.
  4. Otherwise: all stages advance.
- Req and Stall together: Req dominates (flush).
- No state machine beyond the pipeline registers; a bubble never generates a code.
- CP0 suppresses nested exceptions via EXL. This block still reports codes while EXL is set and does not gate them.

Optional Feature:
- Macro: EXC_BD_EN.
- When defined:
  - Extra input F_InDelaySlot (1 bit), set when the F instruction follows a branch/jump.
  - A BD bit is carried per stage with the same advance/hold/bubble/flush rules; bubble and flush BD = 0.
  - Extra outputs: M_BD, 1 bit.
  - M_VPC = M PC − 4 when M_BD=1, so EPC points at the branch.
- When undefined: no BD state or port; M_VPC = M PC.

Decomposition:
- Shared package exc_pkg:
  - ExcCode constants.
  - PC_LO/PC_HI defaults.
  - Function for first-nonzero code merge.
- One natural sub-module, exc_stage_reg: a single PC+code(+BD) pipeline register with Reset/Flush/Hold/Bubble controls, instantiated three times.

Test Plan:
- F_PC=32'h3002, no stalls → after 3 edges M_ExcCode=4, M_VPC=32'h3002.
- F_PC=32'h3004 clean, D_RI=1 at D, E_Ov=1 at E → M_ExcCode=10 (earlier stage wins), M_VPC=32'h3004.
- E_AddrOv=1, E_IsLoad=0 at PC 32'h3010 → next cycle M_ExcCode=5; same case with E_IsLoad=1 → 4.
- Stall=1 for 2 cycles with D_PC=32'h3020 → D_PC held at 32'h3020; E gets bubbles with code 0 and E_PC=32'h3020; M_ExcCode=0 while bubbles pass.
- M_ExcCode=12 and Req=1 asserted with Stall=1 → next edge D, E, M codes=0; Stall ignored that edge.
- Reset=1 mid-stream with pending ADEL in E → next edge M_ExcCode=0, M_VPC=D_PC=E_PC=32'h3000; with EXC_BD_EN, BD=1 at M PC 32'h3008 gives M_VPC=32'h3004.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception codes, legal PC window defaults, per-stage pipeline record and code-merge helper.
// Build option EXC_BD_EN adds a branch-delay (BD) bit to each stage record.
package exc_pkg;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] PC_LO_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_HI_DEF = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  code;
`ifdef EXC_BD_EN
        logic        bd;
`endif
    } stage_t;

    // The oldest exception an instruction picked up is the one CP0 must see.
    function automatic logic [4:0] exc_merge(input logic [4:0] older, input logic [4:0] loc);
        return (older != EXC_NONE) ? older : loc;
    endfunction

endpackage

// File: rtl/exc_pipe_if.sv
// Control, exception-source and CP0-facing signals of exc_pipe; master drives inputs, slave is the pipe.
// Build option EXC_BD_EN adds F_InDelaySlot and M_BD.
interface exc_pipe_if;
    logic        Stall;
    logic        Req;
    logic [31:0] F_PC;
    logic        D_RI;
    logic        D_Syscall;
    logic        E_Ov;
    logic        E_AddrOv;
    logic        E_IsLoad;
    logic        M_AdEL;
    logic        M_AdES;
    logic [31:0] M_VPC;
    logic [4:0]  M_ExcCode;
    logic [31:0] D_PC;
    logic [31:0] E_PC;
`ifdef EXC_BD_EN
    logic        F_InDelaySlot;
    logic        M_BD;

    modport master (
        output Stall, Req, F_PC, D_RI, D_Syscall, E_Ov, E_AddrOv, E_IsLoad, M_AdEL, M_AdES,
               F_InDelaySlot,
        input  M_VPC, M_ExcCode, D_PC, E_PC, M_BD
    );
    modport slave (
        input  Stall, Req, F_PC, D_RI, D_Syscall, E_Ov, E_AddrOv, E_IsLoad, M_AdEL, M_AdES,
               F_InDelaySlot,
        output M_VPC, M_ExcCode, D_PC, E_PC, M_BD
    );
`else
    modport master (
        output Stall, Req, F_PC, D_RI, D_Syscall, E_Ov, E_AddrOv, E_IsLoad, M_AdEL, M_AdES,
        input  M_VPC, M_ExcCode, D_PC, E_PC
    );
    modport slave (
        input  Stall, Req, F_PC, D_RI, D_Syscall, E_Ov, E_AddrOv, E_IsLoad, M_AdEL, M_AdES,
        output M_VPC, M_ExcCode, D_PC, E_PC
    );
`endif
endinterface

// File: rtl/exc_stage_reg.sv
// One PC+code(+BD) pipeline register; priority reset > flush > hold > bubble > load.
// Latency one edge; flush and bubble keep the incoming PC but clear code and BD.
module exc_stage_reg
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_LO_DEF
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   flush,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q    <= '0;
            q.pc <= RESET_PC;
        end else if (flush) begin
            q    <= '0;
            q.pc <= d.pc;
        end else if (!hold) begin
            if (bubble) begin
                q    <= '0;
                q.pc <= d.pc;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/exc_pipe.sv
// Tracks PC and first exception code through D/E/M and presents the M-stage victim to CP0.
// F code reaches M_ExcCode 3 edges later; Stall holds D and bubbles E, Req flushes (EXC_BD_EN adds BD).
module exc_pipe
    import exc_pkg::*;
#(
    parameter logic [31:0] PC_LO = PC_LO_DEF,
    parameter logic [31:0] PC_HI = PC_HI_DEF
) (
    input logic        Clk,
    input logic        Reset,
    exc_pipe_if.slave  bus
);

    logic [4:0] f_code, d_loc, e_loc, m_loc;
    stage_t     d_nxt, e_nxt, m_nxt;
    stage_t     d_q, e_q, m_q;

    always_comb begin
        f_code = EXC_NONE;
        if (bus.F_PC[1:0] != 2'b00 || bus.F_PC < PC_LO || bus.F_PC > PC_HI)
            f_code = EXC_ADEL;

        d_loc = bus.D_RI ? EXC_RI : (bus.D_Syscall ? EXC_SYSCALL : EXC_NONE);

        // Overflow outranks address overflow should both ever be raised together.
        e_loc = EXC_NONE;
        if (bus.E_Ov)
            e_loc = EXC_OV;
        else if (bus.E_AddrOv)
            e_loc = bus.E_IsLoad ? EXC_ADEL : EXC_ADES;

        m_loc = bus.M_AdEL ? EXC_ADEL : (bus.M_AdES ? EXC_ADES : EXC_NONE);
    end

    always_comb begin
        d_nxt      = '0;
        d_nxt.pc   = bus.F_PC;
        d_nxt.code = f_code;
`ifdef EXC_BD_EN
        d_nxt.bd   = bus.F_InDelaySlot;
`endif
        e_nxt      = d_q;
        e_nxt.code = exc_merge(d_q.code, d_loc);
        m_nxt      = e_q;
        m_nxt.code = exc_merge(e_q.code, e_loc);
    end

    exc_stage_reg #(.RESET_PC(PC_LO)) u_d (
        .Clk(Clk), .Reset(Reset), .flush(bus.Req), .hold(bus.Stall), .bubble(1'b0),
        .d(d_nxt), .q(d_q)
    );

    exc_stage_reg #(.RESET_PC(PC_LO)) u_e (
        .Clk(Clk), .Reset(Reset), .flush(bus.Req), .hold(1'b0), .bubble(bus.Stall),
        .d(e_nxt), .q(e_q)
    );

    exc_stage_reg #(.RESET_PC(PC_LO)) u_m (
        .Clk(Clk), .Reset(Reset), .flush(bus.Req), .hold(1'b0), .bubble(1'b0),
        .d(m_nxt), .q(m_q)
    );

    assign bus.M_ExcCode = exc_merge(m_q.code, m_loc);
    assign bus.D_PC      = d_q.pc;
    assign bus.E_PC      = e_q.pc;
`ifdef EXC_BD_EN
    // EPC must point at the branch when the victim sits in its delay slot.
    assign bus.M_VPC     = m_q.bd ? (m_q.pc - 32'd4) : m_q.pc;
    assign bus.M_BD      = m_q.bd;
`else
    assign bus.M_VPC     = m_q.pc;
`endif

endmodule

// File: tb/tb_exc_pipe.sv
// Scoreboarded bench for exc_pipe: directed cases then random traffic against an instruction-slot model.
// Build option EXC_BD_EN enables delay-slot stimulus and M_BD checking.
module tb_exc_pipe;

    logic Clk = 1'b0;
    logic Reset;

    exc_pipe_if bus();

    exc_pipe dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst, stall, req;
        logic [31:0] pc;
        logic        ri, sys, ov, aov, ld, adel, ades, ds;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  code;
        logic        bd;
    } slot_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] vpc, dpc, epc;
        logic        bd;
    } exp_t;

`ifdef EXC_BD_EN
    localparam bit BD_ON = 1'b1;
`else
    localparam bit BD_ON = 1'b0;
`endif

    slot_t md, me, mm;
    vec_t  prev;
    exp_t  sb[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic logic [4:0] first3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        if (a != 0) return a;
        if (b != 0) return b;
        return c;
    endfunction

    function automatic logic [4:0] f_exc(input logic [31:0] pc);
        return (pc % 4 != 0 || pc < 32'h3000 || pc > 32'h6FFC) ? 5'd4 : 5'd0;
    endfunction

    function automatic logic [4:0] d_exc(input vec_t v);
        return first3(v.ri ? 5'd10 : 5'd0, v.sys ? 5'd8 : 5'd0, 5'd0);
    endfunction

    function automatic logic [4:0] e_exc(input vec_t v);
        return first3(v.ov ? 5'd12 : 5'd0, v.aov ? (v.ld ? 5'd4 : 5'd5) : 5'd0, 5'd0);
    endfunction

    function automatic logic [4:0] m_exc(input vec_t v);
        return first3(v.adel ? 5'd4 : 5'd0, v.ades ? 5'd5 : 5'd0, 5'd0);
    endfunction

    // Instruction slots move one place per edge; bubbles are PC-only slots with no exception.
    task automatic model_edge();
        slot_t nd, ne, nm;
        if (prev.rst) begin
            md = '{pc: 32'h3000, code: 5'd0, bd: 1'b0};
            me = md;
            mm = md;
        end else begin
            nd = '{pc: prev.pc, code: f_exc(prev.pc), bd: BD_ON & prev.ds};
            ne = '{pc: md.pc, code: first3(md.code, d_exc(prev), 5'd0), bd: md.bd};
            nm = '{pc: me.pc, code: first3(me.code, e_exc(prev), 5'd0), bd: me.bd};
            if (prev.req) begin
                mm = '{pc: me.pc, code: 5'd0, bd: 1'b0};
                me = '{pc: md.pc, code: 5'd0, bd: 1'b0};
                md = '{pc: prev.pc, code: 5'd0, bd: 1'b0};
            end else if (prev.stall) begin
                mm = nm;
                me = '{pc: md.pc, code: 5'd0, bd: 1'b0};
            end else begin
                mm = nm;
                me = ne;
                md = nd;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        Reset         = v.rst;
        bus.Stall     = v.stall;
        bus.Req       = v.req;
        bus.F_PC      = v.pc;
        bus.D_RI      = v.ri;
        bus.D_Syscall = v.sys;
        bus.E_Ov      = v.ov;
        bus.E_AddrOv  = v.aov;
        bus.E_IsLoad  = v.ld;
        bus.M_AdEL    = v.adel;
        bus.M_AdES    = v.ades;
`ifdef EXC_BD_EN
        bus.F_InDelaySlot = v.ds;
`endif
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge Clk);
        model_edge();
        #1;
        drive(v);
        e.code = first3(mm.code, m_exc(v), 5'd0);
        e.vpc  = mm.bd ? mm.pc - 32'd4 : mm.pc;
        e.dpc  = md.pc;
        e.epc  = me.pc;
        e.bd   = mm.bd;
        sb.push_back(e);
        prev = v;
    endtask

    function automatic vec_t dv(input logic [31:0] pc);
        vec_t v;
        v    = '0;
        v.pc = pc;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v = '0;
        v.rst   = ($urandom_range(0, 59) == 0);
        v.stall = ($urandom_range(0, 4) == 0);
        v.req   = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 7))
            0:       v.pc = 32'h2FFC;
            1:       v.pc = 32'h3000;
            2:       v.pc = 32'h6FFC;
            3:       v.pc = 32'h7000;
            4:       v.pc = $urandom;
            5:       v.pc = 32'h3000 + $urandom_range(0, 16383);
            default: v.pc = 32'h3000 + 32'($urandom_range(0, 4095) << 2);
        endcase
        v.ri   = ($urandom_range(0, 7) == 0);
        v.sys  = ($urandom_range(0, 7) == 0);
        v.ov   = ($urandom_range(0, 7) == 0);
        v.aov  = ($urandom_range(0, 7) == 0);
        v.ld   = ($urandom_range(0, 1) == 0);
        v.adel = ($urandom_range(0, 7) == 0);
        v.ades = ($urandom_range(0, 7) == 0);
        v.ds   = ($urandom_range(0, 3) == 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("M_ExcCode", 32'(bus.M_ExcCode), 32'(e.code));
            chk("M_VPC", bus.M_VPC, e.vpc);
            chk("D_PC", bus.D_PC, e.dpc);
            chk("E_PC", bus.E_PC, e.epc);
`ifdef EXC_BD_EN
            chk("M_BD", 32'(bus.M_BD), 32'(e.bd));
`endif
        end
    end

    initial begin
        vec_t v;
        prev = dv(32'h3000);
        prev.rst = 1'b1;
        drive(prev);
        step(prev);
        step(prev);

        // Misaligned fetch travels to M.
        step(dv(32'h3002));
        step(dv(32'h3004));
        // RI on 0x3004 in D, later OV on it in E: the older code must survive.
        v = dv(32'h3008); v.ri = 1'b1; step(v);
        v = dv(32'h300C); v.ov = 1'b1; step(v);
        step(dv(32'h3010));
        step(dv(32'h3014));
        v = dv(32'h3018); v.aov = 1'b1; step(v);
        v = dv(32'h301C); v.aov = 1'b1; v.ld = 1'b1; step(v);
        step(dv(32'h3020));
        step(dv(32'h3024));
        v = dv(32'h3028); v.stall = 1'b1; step(v);
        step(v);
        step(dv(32'h302C));
        step(dv(32'h3030));
        // Flush together with stall: flush wins.
        v = dv(32'h3034); v.req = 1'b1; v.stall = 1'b1; v.ri = 1'b1; v.ov = 1'b1; step(v);
        step(dv(32'h3038));
        step(dv(32'h3001));
        step(dv(32'h3040));
        v = dv(32'h3044); v.rst = 1'b1; step(v);
        step(dv(32'h3000));
        v = dv(32'h3004); v.ds = 1'b1; step(v);
        v = dv(32'h3008); v.ds = 1'b1; step(v);
        step(dv(32'h300C));
        step(dv(32'h3010));
        step(dv(32'h3014));
        step(dv(32'h2FFC));
        step(dv(32'h7000));
        step(dv(32'h6FFC));
        step(dv(32'h3018));
        step(dv(32'h301C));

        for (int i = 0; i < 3000; i++)
            step(rnd_vec());

        @(negedge Clk);
        @(posedge Clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
